// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
// Holds the FSM state encoding and the counter width function.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..steps-1, never less than one.
  function automatic int cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from a chain of full adders.
// With DIGIT=1 it is a single full adder, the half adder plus carry-in.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per
// clock, with valid/ready handshakes on the operand and result sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one digit added per cycle, STEPS cycles
// DONE  | result presented, out_valid=1 until out_ready
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_adder: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
  end

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic             carry;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic [DIGIT-1:0] dig_s;
  logic             dig_co;
  logic [WIDTH+DIGIT-1:0] sum_cat;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x  (a_sr[DIGIT-1:0]),
    .y  (b_sr[DIGIT-1:0]),
    .ci (carry),
    .s  (dig_s),
    .co (dig_co)
  );

  // New digit enters at the top; the concatenation also covers DIGIT==WIDTH.
  assign sum_cat = {dig_s, sum_sr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)      state_nx = RUN;
      RUN:     if (count == LAST) state_nx = DONE;
      DONE:    if (out_ready)     state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      carry  <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr   <= a;
          b_sr   <= b;
          carry  <= cin;
          count  <= '0;
          sign_a <= a[WIDTH-1];
          sign_b <= b[WIDTH-1];
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          sum_sr <= sum_cat[WIDTH+DIGIT-1:DIGIT];
          carry  <= dig_co;
          count  <= count + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum      = sum_sr;
  assign cout     = carry;
  assign overflow = (sign_a == sign_b) && (sum_sr[WIDTH-1] != sign_a);

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the team's single-bit adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, with a ripple carry held in a register between cycles.
- Has valid/ready handshakes on input and output, so it sits between stream stages where area matters more than latency.
- Reports carry-out and signed overflow.

Parameters:
- WIDTH, 8, operand and sum width in bits.
- DIGIT, 1, bits processed per cycle. Must divide WIDTH exactly; checked by an elaboration-time assertion.
- STEPS (localparam), WIDTH/DIGIT, number of compute cycles.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and cin are valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result valid (high only in DONE).
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  a+b+cin modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- overflow  out  1  two's-complement signed overflow.

Behaviour:
- Reset (async, rst=1): state=IDLE; count, carry and the operand/sum shift registers clear to 0. Outputs during and after reset: sum=0, cout=0, overflow=0, out_valid=0, in_ready=1.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: load a and b into shift registers, carry<=cin, count<=0, capture sign bits a[WIDTH-1] and b[WIDTH-1], go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored and no operand is captured.
  - Each cycle: digit result = a_sr[DIGIT-1:0] + b_sr[DIGIT-1:0] + carry (DIGIT+1 bits).
  - Shift the low DIGIT bits of the digit result into the top of sum_sr; the register shifts right by DIGIT.
  - Shift a_sr and b_sr right by DIGIT; carry<=bit DIGIT of the digit result; count<=count+1.
  - When count==STEPS-1, that cycle's digit is the last: go to DONE.
- DONE:
  - out_valid=1. sum=sum_sr, cout=carry.
  - overflow=(signA==signB)&&(sum[WIDTH-1]!=signA).
  - Outputs hold stable until out_ready=1. On that edge go to IDLE; sum, cout and overflow keep their values but are don't-care while out_valid=0.
- Latency: operands accepted at edge N, out_valid rises after edge N+STEPS. Minimum initiation interval is STEPS+2 cycles (accept, STEPS compute, drain).
- No overlap: in_ready and out_valid are never both high. A new operand is not accepted in the same cycle a result drains.
- count width is clog2(STEPS), minimum 1. For STEPS==1, RUN lasts one cycle.
- Wrap-around: the sum is modulo 2^WIDTH. The carry beyond the MSB appears only on cout.
- Reset mid-RUN or mid-DONE: aborts immediately. The result is lost, all outputs take their reset values, and no out_valid pulse follows.
- in_valid/out_ready changes outside IDLE/DONE respectively have no effect.

Decomposition:
- Shared package serial_adder_pkg:
  - state typedef {IDLE, RUN, DONE} (2-bit encoding).
  - helper constant function for the count width.
- One sub-module: digit_adder. It is combinational DIGIT-bit ripple adder (inputs x, y, ci; outputs s[DIGIT-1:0], co), built as a chain of full adders, and is the direct generalisation of the half adder.
- serial_adder instantiates one digit_adder and owns the FSM, counter and shift registers.

Test Plan:
1. WIDTH=8, DIGIT=1: a=0x5A, b=0x3C, cin=0 -> after 8 compute cycles out_valid=1, sum=0x96, cout=0, overflow=1.
2. WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Also a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, overflow=1.
3. WIDTH=8, DIGIT=4: a=0xFF, b=0xFF, cin=1 -> out_valid rises 2 cycles after accept, sum=0xFF, cout=1, overflow=0.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum/cout/overflow/out_valid stable, in_ready=0 throughout; out_ready=1 -> next cycle in_ready=1, out_valid=0.
5. in_valid=1 with new operands during RUN -> ignored; the result equals the first operands' sum, and exactly one out_valid episode occurs.
6. Assert rst asynchronously at the 3rd RUN cycle -> out_valid=0, sum=0, cout=0, in_ready=1 without waiting for an edge. A fresh a=0x01, b=0x02 then yields sum=0x03.
